// File: rtl/branch_target_buffer.sv
// Tagged, direct-mapped branch target buffer with per-entry saturating direction
// counters, combinational fetch lookup, single training port and saturating perf counters.
module branch_target_buffer #(
    parameter int ENTRIES        = 16,
    parameter int COUNTER_WIDTH  = 2,
    parameter int COUNT_WIDTH    = 32,
    parameter bit PREDICT_ENABLE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_lookup,
    input  logic [31:0]            if_pc,
    output logic                   predict_taken,
    output logic [31:0]            predict_target,
    input  logic                   mb_update,
    input  logic [31:0]            mb_pc,
    input  logic                   mb_is_jump,
    input  logic                   mb_taken,
    input  logic [31:0]            mb_target,
    input  logic                   mb_predict_taken,
    input  logic [31:0]            mb_predict_target,
    input  logic                   invalidate,
    output logic [COUNT_WIDTH-1:0] branch_count,
    output logic [COUNT_WIDTH-1:0] mispredict_count
);

    localparam int INDEX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS   = 30 - INDEX_BITS;
    localparam logic [COUNTER_WIDTH-1:0] CTR_MAX  = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] CTR_ZERO = {COUNTER_WIDTH{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0] CTR_ONE  = COUNTER_WIDTH'(1'b1);
    // Weakly-taken: only the MSB set.
    localparam logic [COUNTER_WIDTH-1:0] CTR_WEAK = CTR_MAX ^ (CTR_MAX >> 1);
    localparam logic [COUNT_WIDTH-1:0]   CNT_MAX  = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0]   CNT_ONE  = COUNT_WIDTH'(1'b1);

    logic [ENTRIES-1:0]       valid_r;
    logic [ENTRIES-1:0]       jump_r;
    logic [TAG_BITS-1:0]      tag_r    [ENTRIES];
    logic [31:0]              target_r [ENTRIES];
    logic [COUNTER_WIDTH-1:0] ctr_r    [ENTRIES];
    logic [COUNT_WIDTH-1:0]   branch_count_r;
    logic [COUNT_WIDTH-1:0]   mispredict_count_r;

    logic [INDEX_BITS-1:0]    lk_idx_s;
    logic                     lk_hit_s;
    logic                     lk_taken_s;
    logic [INDEX_BITS-1:0]    up_idx_s;
    logic                     up_hit_s;
    logic                     up_write_s;
    logic                     mispredict_s;
    logic [COUNTER_WIDTH-1:0] ctr_next_s;
    logic [31:0]              target_next_s;
    logic                     unused_s;

    assign unused_s = ^{if_pc[1:0], mb_pc[1:0]};

    // Fetch lookup reads only pre-edge table state; there is no update bypass.
    always_comb begin
        lk_idx_s   = if_pc[INDEX_BITS+1:2];
        lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == if_pc[31:INDEX_BITS+2]);
        lk_taken_s = PREDICT_ENABLE && if_lookup && lk_hit_s
                     && (jump_r[lk_idx_s] || ctr_r[lk_idx_s][COUNTER_WIDTH-1]);
    end

    assign predict_taken  = lk_taken_s;
    assign predict_target = lk_taken_s ? target_r[lk_idx_s] : (if_pc + 32'd4);

    // Training decode: hit detection, mispredict flag and next entry contents.
    always_comb begin
        up_idx_s     = mb_pc[INDEX_BITS+1:2];
        up_hit_s     = valid_r[up_idx_s] && (tag_r[up_idx_s] == mb_pc[31:INDEX_BITS+2]);
        mispredict_s = mb_update && ((mb_taken != mb_predict_taken)
                       || (mb_taken && (mb_target != mb_predict_target)));
        // Misses only allocate when taken; invalidate and reset suppress any write.
        up_write_s   = mb_update && !rst && !invalidate && (up_hit_s || mb_taken);
        if (mb_is_jump) begin
            ctr_next_s = CTR_MAX;
        end else if (!up_hit_s) begin
            ctr_next_s = CTR_WEAK;
        end else if (mb_taken) begin
            ctr_next_s = (ctr_r[up_idx_s] == CTR_MAX) ? CTR_MAX : ctr_r[up_idx_s] + CTR_ONE;
        end else begin
            ctr_next_s = (ctr_r[up_idx_s] == CTR_ZERO) ? CTR_ZERO : ctr_r[up_idx_s] - CTR_ONE;
        end
        target_next_s = mb_taken ? mb_target : target_r[up_idx_s];
    end

    // Valid bits and performance counters; the only reset state.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r            <= {ENTRIES{1'b0}};
            branch_count_r     <= {COUNT_WIDTH{1'b0}};
            mispredict_count_r <= {COUNT_WIDTH{1'b0}};
        end else begin
            if (invalidate) begin
                valid_r <= {ENTRIES{1'b0}};
            end else if (up_write_s) begin
                valid_r[up_idx_s] <= 1'b1;
            end
            if (mb_update && (branch_count_r != CNT_MAX)) begin
                branch_count_r <= branch_count_r + CNT_ONE;
            end
            if (mispredict_s && (mispredict_count_r != CNT_MAX)) begin
                mispredict_count_r <= mispredict_count_r + CNT_ONE;
            end
        end
    end

    // Entry payload; contents of invalid entries are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (up_write_s) begin
            tag_r[up_idx_s]    <= mb_pc[31:INDEX_BITS+2];
            target_r[up_idx_s] <= target_next_s;
            jump_r[up_idx_s]   <= mb_is_jump;
            ctr_r[up_idx_s]    <= ctr_next_s;
        end
    end

    assign branch_count     = branch_count_r;
    assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: a default instance and a COUNT_WIDTH=4,
// PREDICT_ENABLE=0 instance share stimulus and are checked against a table model.
module tb_branch_target_buffer;

    logic        clk;
    logic        rst;
    logic        if_lookup;
    logic [31:0] if_pc;
    logic        mb_update;
    logic [31:0] mb_pc;
    logic        mb_is_jump;
    logic        mb_taken;
    logic [31:0] mb_target;
    logic        mb_predict_taken;
    logic [31:0] mb_predict_target;
    logic        invalidate;

    logic        a_taken;
    logic [31:0] a_target;
    logic [31:0] a_bc;
    logic [31:0] a_mc;
    logic        b_taken;
    logic [31:0] b_target;
    logic [3:0]  b_bc;
    logic [3:0]  b_mc;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: per-index entry with full PC tag and an integer direction counter 0..3.
    bit          m_ready = 1'b0;
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    bit          m_jump  [16];
    int          m_ctr   [16];
    int          m_bc;
    int          m_mc;

    branch_target_buffer dut (
        .clk(clk), .rst(rst), .if_lookup(if_lookup), .if_pc(if_pc),
        .predict_taken(a_taken), .predict_target(a_target),
        .mb_update(mb_update), .mb_pc(mb_pc), .mb_is_jump(mb_is_jump),
        .mb_taken(mb_taken), .mb_target(mb_target),
        .mb_predict_taken(mb_predict_taken), .mb_predict_target(mb_predict_target),
        .invalidate(invalidate), .branch_count(a_bc), .mispredict_count(a_mc)
    );

    branch_target_buffer #(.COUNT_WIDTH(4), .PREDICT_ENABLE(1'b0)) dut_np (
        .clk(clk), .rst(rst), .if_lookup(if_lookup), .if_pc(if_pc),
        .predict_taken(b_taken), .predict_target(b_target),
        .mb_update(mb_update), .mb_pc(mb_pc), .mb_is_jump(mb_is_jump),
        .mb_taken(mb_taken), .mb_target(mb_target),
        .mb_predict_taken(mb_predict_taken), .mb_predict_target(mb_predict_target),
        .invalidate(invalidate), .branch_count(b_bc), .mispredict_count(b_mc)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic compare_cycle();
        int          i;
        bit          hit;
        bit          tk;
        logic [31:0] tg;
        i   = int'(if_pc[5:2]);
        hit = m_valid[i] && (m_tag[i] == (if_pc >> 6));
        tk  = if_lookup && hit && (m_jump[i] || (m_ctr[i] >= 2));
        tg  = tk ? m_tgt[i] : if_pc + 32'd4;
        chk("cyc_a_taken", 32'(a_taken), 32'(tk));
        chk("cyc_a_target", a_target, tg);
        chk("cyc_a_bc", a_bc, 32'(m_bc));
        chk("cyc_a_mc", a_mc, 32'(m_mc));
        chk("cyc_b_taken", 32'(b_taken), 32'd0);
        chk("cyc_b_target", b_target, if_pc + 32'd4);
        chk("cyc_b_bc", 32'(b_bc), 32'(sat15(m_bc)));
        chk("cyc_b_mc", 32'(b_mc), 32'(sat15(m_mc)));
    endtask

    task automatic model_step();
        int i;
        bit hit;
        if (rst) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
            m_bc    = 0;
            m_mc    = 0;
            m_ready = 1'b1;
        end else begin
            if (mb_update) begin
                m_bc++;
                if ((mb_taken != mb_predict_taken) || (mb_taken && (mb_target != mb_predict_target)))
                    m_mc++;
            end
            if (invalidate) begin
                for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
            end else if (mb_update) begin
                i   = int'(mb_pc[5:2]);
                hit = m_valid[i] && (m_tag[i] == (mb_pc >> 6));
                if (hit) begin
                    if (mb_is_jump) m_ctr[i] = 3;
                    else if (mb_taken) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    if (mb_taken) m_tgt[i] = mb_target;
                    m_jump[i] = mb_is_jump;
                end else if (mb_taken) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = mb_pc >> 6;
                    m_tgt[i]   = mb_target;
                    m_jump[i]  = mb_is_jump;
                    m_ctr[i]   = mb_is_jump ? 3 : 2;
                end
            end
        end
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so the negedge sees
    // the values the coming edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (m_ready) compare_cycle();
            model_step();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic idle();
        rst = 1'b0; if_lookup = 1'b0; if_pc = 32'h0;
        mb_update = 1'b0; mb_pc = 32'h0; mb_is_jump = 1'b0; mb_taken = 1'b0;
        mb_target = 32'h0; mb_predict_taken = 1'b0; mb_predict_target = 32'h0;
        invalidate = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic jmp, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptg);
        mb_update = 1'b1; mb_pc = pc; mb_is_jump = jmp; mb_taken = tk;
        mb_target = tgt; mb_predict_taken = ptk; mb_predict_target = ptg;
    endtask

    task automatic train(input logic [31:0] pc, input logic jmp, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptg);
        set_upd(pc, jmp, tk, tgt, ptk, ptg);
        tick();
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic etk,
                        input logic [31:0] etg);
        if_lookup = 1'b1;
        if_pc     = pc;
        #1;
        chk({name, "_taken"}, 32'(a_taken), 32'(etk));
        chk({name, "_target"}, a_target, etg);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();

        look("rst_look", 32'h100, 1'b0, 32'h104);
        chk("rst_bc", a_bc, 32'd0);
        chk("rst_mc", a_mc, 32'd0);
        tick();

        train(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        chk("alloc_bc", a_bc, 32'd1);
        chk("alloc_mc", a_mc, 32'd1);
        look("alloc", 32'h100, 1'b1, 32'h80);
        tick();

        // Counter 2 -> 3 -> 3, then down.
        train(32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
        train(32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
        train(32'h100, 1'b0, 1'b0, 32'h104, 1'b1, 32'h80);
        look("hyst1", 32'h100, 1'b1, 32'h80);
        tick();
        train(32'h100, 1'b0, 1'b0, 32'h104, 1'b1, 32'h80);
        look("hyst2", 32'h100, 1'b0, 32'h104);
        tick();
        train(32'h100, 1'b0, 1'b0, 32'h104, 1'b0, 32'h104);
        train(32'h100, 1'b0, 1'b0, 32'h104, 1'b0, 32'h104);
        train(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        look("floor", 32'h100, 1'b0, 32'h104);
        chk("hyst_bc", a_bc, 32'd8);
        chk("hyst_mc", a_mc, 32'd4);
        tick();

        // 0x140 and 0x200 share index 0 with 0x100.
        train(32'h140, 1'b0, 1'b1, 32'h300, 1'b0, 32'h144);
        look("alias_new", 32'h140, 1'b1, 32'h300);
        tick();
        look("alias_old", 32'h100, 1'b0, 32'h104);
        tick();
        train(32'h200, 1'b0, 1'b0, 32'h204, 1'b0, 32'h204);
        look("nt_miss", 32'h200, 1'b0, 32'h204);
        tick();
        look("nt_keep", 32'h140, 1'b1, 32'h300);
        tick();

        train(32'h104, 1'b1, 1'b1, 32'h500, 1'b0, 32'h108);
        look("jump", 32'h104, 1'b1, 32'h500);
        tick();
        train(32'h104, 1'b0, 1'b0, 32'h108, 1'b1, 32'h500);
        look("jump_clr1", 32'h104, 1'b1, 32'h500);
        tick();
        train(32'h104, 1'b0, 1'b0, 32'h108, 1'b1, 32'h500);
        look("jump_clr2", 32'h104, 1'b0, 32'h108);
        tick();

        // Same-cycle lookup sees pre-update state.
        set_upd(32'h140, 1'b0, 1'b0, 32'h144, 1'b1, 32'h300);
        look("same_cyc1", 32'h140, 1'b1, 32'h300);
        tick();
        look("after_nt", 32'h140, 1'b0, 32'h144);
        tick();
        set_upd(32'h140, 1'b0, 1'b1, 32'h340, 1'b0, 32'h144);
        look("same_cyc2", 32'h140, 1'b0, 32'h144);
        tick();
        look("after_tk", 32'h140, 1'b1, 32'h340);
        tick();

        set_upd(32'h180, 1'b0, 1'b1, 32'h600, 1'b0, 32'h184);
        invalidate = 1'b1;
        tick();
        look("inv_new", 32'h180, 1'b0, 32'h184);
        tick();
        look("inv_old", 32'h140, 1'b0, 32'h144);
        tick();

        train(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        look("pre_rst", 32'h100, 1'b1, 32'h80);
        tick();
        set_upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        rst = 1'b1;
        tick();
        look("rst_upd", 32'h100, 1'b0, 32'h104);
        chk("rst_upd_bc", a_bc, 32'd0);
        chk("rst_upd_mc", a_mc, 32'd0);
        chk("rst_upd_b_bc", 32'(b_bc), 32'd0);
        tick();

        for (int n = 0; n < 20; n++) train(32'h10, 1'b0, 1'b1, 32'h40, 1'b0, 32'h14);
        chk("sat_a_bc", a_bc, 32'd20);
        chk("sat_a_mc", a_mc, 32'd20);
        chk("sat_b_bc", 32'(b_bc), 32'd15);
        chk("sat_b_mc", 32'(b_mc), 32'd15);
        look("dis_a", 32'h10, 1'b1, 32'h40);
        chk("dis_b_taken", 32'(b_taken), 32'd0);
        chk("dis_b_target", b_target, 32'h14);
        tick();

        // Right direction, wrong target still mispredicts and retrains the target.
        train(32'h10, 1'b0, 1'b1, 32'h44, 1'b1, 32'h40);
        chk("tgt_mp_mc", a_mc, 32'd21);
        chk("tgt_mp_bc", a_bc, 32'd21);
        look("tgt_retrain", 32'h10, 1'b1, 32'h44);
        tick();

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Parametrised, tagged, direct-mapped branch target buffer with per-entry saturating direction counters. It replaces the fetch stage's static prediction source for predict_taken/predict_target. Fetch performs a same-cycle combinational lookup. The mem_branch stage trains the table with resolved outcomes. The block also keeps saturating performance counters for resolved branches and mispredictions.

Parameters:
ENTRIES, 16, number of table entries; power of two, at least 2; INDEX_BITS = $clog2(ENTRIES)
COUNTER_WIDTH, 2, width of each direction counter; at least 1
COUNT_WIDTH, 32, width of each performance counter
PREDICT_ENABLE, 1, when 0 predict_taken is forced 0; the table still trains

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
if_lookup  input  1  fetch lookup valid
if_pc  input  32  fetch PC to predict
predict_taken  output  1  predicted taken (combinational)
predict_target  output  32  predicted next PC (combinational)
mb_update  input  1  resolved control-transfer instruction present in mb stage
mb_pc  input  32  PC of the resolved instruction
mb_is_jump  input  1  1 = unconditional (jal/jalr), 0 = conditional branch
mb_taken  input  1  resolved direction
mb_target  input  32  resolved target
mb_predict_taken  input  1  prediction originally issued for this instruction
mb_predict_target  input  32  target originally issued for this instruction
invalidate  input  1  clear all entries (fence.i, context change)
branch_count  output  COUNT_WIDTH  resolved updates seen, saturating
mispredict_count  output  COUNT_WIDTH  mispredictions seen, saturating

Behaviour:
- Entry fields: valid, tag[31:INDEX_BITS+2], target[31:0], jump flag, counter[COUNTER_WIDTH-1:0].
- Addressing: index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2].
- Lookup (combinational):
  - hit = valid[idx] && tag matches.
  - taken = PREDICT_ENABLE && if_lookup && hit && (jump flag || counter MSB).
  - predict_target = taken ? entry target : if_pc + 4 (32-bit wrap).
- Lookup vs update collision: a lookup always sees pre-edge state, including same-cycle updates to the same index. No bypass.
- Mispredict condition: mb_update && ((mb_taken != mb_predict_taken) || (mb_taken && mb_target != mb_predict_target)).
- Update on hit (mb_update, tag match at index(mb_pc)):
  - taken: counter +1, saturating at 2^COUNTER_WIDTH-1; target <= mb_target.
  - not taken: counter -1, saturating at 0; target unchanged.
  - jump flag <= mb_is_jump; if mb_is_jump, counter <= max.
- Update on miss:
  - mb_taken=1: allocate, overwriting any aliased entry. valid=1, tag, target=mb_target, jump flag=mb_is_jump, counter = mb_is_jump ? max : 2^(COUNTER_WIDTH-1) (weakly taken).
  - mb_taken=0: no allocation, table unchanged.
- invalidate: all valid bits cleared at the next edge. Overrides any same-cycle update, so no allocation or training happens. Performance counters still count that update.
- Performance counters:
  - branch_count +1 on every mb_update.
  - mispredict_count +1 on every mispredict.
  - Both saturate at all-ones; no wrap.
- Reset:
  - Clears all valid bits, branch_count=0, mispredict_count=0. Tags, targets and counters are don't-care.
  - During and after reset, predict_taken=0 and predict_target=if_pc+4.
  - rst overrides update and invalidate in the same cycle.
  - Reset mid-training discards that cycle's update.
- Storage is registers, no RAM inference. Single write port (one update per cycle); one combinational read port.

Test Plan:
- Reset: assert rst 1 cycle; lookup if_pc=0x100 -> predict_taken=0, predict_target=0x104; both counts 0.
- Allocate and predict: update pc=0x100, branch, taken, target=0x80, mb_predict_taken=0 -> branch_count=1, mispredict_count=1. Next cycle lookup 0x100 -> taken=1, target=0x80 (counter=2).
- Hysteresis: two more taken updates (counter 3), then one not-taken -> still predicts 0x80. Second not-taken -> counter 1, predict_taken=0, target=0x104. Counter floors at 0 after further not-taken updates.
- Aliasing (ENTRIES=16): taken update pc=0x140 (same index, different tag) -> lookup 0x140 hits 0x140's target; lookup 0x100 now misses. Not-taken update on a missing pc=0x200 -> no allocation.
- Simultaneous events: (a) update and lookup to 0x100 in the same cycle -> lookup returns pre-update prediction. (b) invalidate with a taken update -> all lookups miss next cycle, branch_count still increments. (c) rst with update -> table empty, counts 0.
- Saturation and disable: COUNT_WIDTH=4, 20 mispredicting updates -> mispredict_count=15, branch_count=15. PREDICT_ENABLE=0 with a trained entry -> predict_taken=0, target=if_pc+4.
